mmio_interconnect: RTL and testbench

- Parametrised memory-mapped peripheral interconnect for the CPU data path, replacing the fixed one-hot peripheral read mux.
- Takes one master request (address, data, read/write) and decodes it to one of NCH peripheral windows, or to a default port (external SRAM).
- Runs a request/acknowledge handshake with each target and returns registered read data to the master.
- Optionally aborts a stalled access with an error response after a bounded wait.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_decode.sv | 36 +++
 rtl/mmio_interconnect.sv | 211 +++++++++++++++++++++
 tb/tb_mmio_interconnect.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding, default memory map,
// and the fixed channel assignment of the CPU peripherals.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int          DEF_NCH         = 6;
  localparam logic [15:0] DEF_BASE        = 16'hFF00;
  localparam int          DEF_REGION_BITS = 4;
  localparam logic [15:0] DEF_ERR_DATA    = 16'hDEAD;

  localparam int CH_STATUS    = 0;
  localparam int CH_ADDRSTACK = 1;
  localparam int CH_USERSTACK = 2;
  localparam int CH_UART      = 3;
  localparam int CH_GPIO      = 4;
  localparam int CH_GPIODIR   = 5;

endpackage

// File: rtl/mmio_decode.sv
// Combinational address decoder: maps an address to a one-hot peripheral window,
// a default-port flag, and the word offset inside the window.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int             AW          = 16,
  parameter int             NCH         = DEF_NCH,
  parameter logic [AW-1:0]  BASE        = AW'(DEF_BASE),
  parameter int             REGION_BITS = DEF_REGION_BITS
) (
  input  logic [AW-1:0]          addr,
  output logic [NCH-1:0]         sel,
  output logic                   dflt,
  output logic [REGION_BITS-1:0] offset
);

  // One extra bit so the span itself cannot overflow the compare.
  localparam logic [AW:0] WIN_SPAN = (AW+1)'(NCH) << REGION_BITS;

  logic [AW-1:0] diff;
  logic [AW-1:0] chan;
  logic          in_win;

  always_comb begin
    diff   = addr - BASE;
    in_win = (addr >= BASE) && ({1'b0, diff} < WIN_SPAN);
    chan   = diff >> REGION_BITS;
    offset = diff[REGION_BITS-1:0];
    dflt   = !in_win;
    sel    = '0;
    for (int k = 0; k < NCH; k++) begin
      sel[k] = in_win && (chan == AW'(k));
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Master-to-peripheral MMIO interconnect with req/ack handshake and registered response.
// Build option: MMIO_TIMEOUT_EN adds an ACCESS watchdog that aborts with an error response.
//
// state  | meaning
// IDLE   | waiting for m_req; captures request and decodes target
// ACCESS | one select held until the selected target acks (or watchdog expires)
// RESP   | response staged; m_ready pulses on the way back to IDLE
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int             AW          = 16,
  parameter int             DW          = 16,
  parameter int             NCH         = DEF_NCH,
  parameter logic [AW-1:0]  BASE        = AW'(DEF_BASE),
  parameter int             REGION_BITS = DEF_REGION_BITS,
  parameter int             TIMEOUT     = 255,
  parameter logic [DW-1:0]  ERR_DATA    = DW'(DEF_ERR_DATA)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   m_req,
  input  logic                   m_write,
  input  logic [AW-1:0]          m_addr,
  input  logic [DW-1:0]          m_wdata,
  output logic                   m_busy,
  output logic                   m_ready,
  output logic [DW-1:0]          m_rdata,
  output logic                   m_err,
  output logic [NCH-1:0]         s_sel,
  output logic                   s_write,
  output logic [REGION_BITS-1:0] s_addr,
  output logic [DW-1:0]          s_wdata,
  input  logic [NCH*DW-1:0]      s_rdata,
  input  logic [NCH-1:0]         s_ack,
  output logic                   d_sel,
  output logic [AW-1:0]          d_addr,
  input  logic [DW-1:0]          d_rdata,
  input  logic                   d_ack
);

  logic [NCH-1:0]         dec_sel;
  logic                   dec_dflt;
  logic [REGION_BITS-1:0] dec_offset;

  mmio_decode #(
    .AW          (AW),
    .NCH         (NCH),
    .BASE        (BASE),
    .REGION_BITS (REGION_BITS)
  ) u_decode (
    .addr   (m_addr),
    .sel    (dec_sel),
    .dflt   (dec_dflt),
    .offset (dec_offset)
  );

  state_e                 state_q, state_d;
  logic                   m_busy_q, m_busy_d;
  logic                   m_ready_q, m_ready_d;
  logic [DW-1:0]          m_rdata_q, m_rdata_d;
  logic [DW-1:0]          rsp_data_q, rsp_data_d;
  logic [NCH-1:0]         s_sel_q, s_sel_d;
  logic                   s_write_q, s_write_d;
  logic [REGION_BITS-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0]          s_wdata_q, s_wdata_d;
  logic                   d_sel_q, d_sel_d;
  logic [AW-1:0]          d_addr_q, d_addr_d;

`ifdef MMIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          pend_err_q, pend_err_d;
  logic          m_err_q, m_err_d;
`endif

  logic          ack_hit;
  logic [DW-1:0] sel_rdata;

  // Only the selected target's ack and data are looked at.
  always_comb begin
    ack_hit   = (|(s_ack & s_sel_q)) | (d_ack & d_sel_q);
    sel_rdata = d_sel_q ? d_rdata : '0;
    for (int k = 0; k < NCH; k++) begin
      if (s_sel_q[k]) sel_rdata = s_rdata[k*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata_q;
    rsp_data_d = rsp_data_q;
    s_sel_d    = s_sel_q;
    s_write_d  = s_write_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    d_sel_d    = d_sel_q;
    d_addr_d   = d_addr_q;
`ifdef MMIO_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    pend_err_d = pend_err_q;
    m_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          state_d   = ST_ACCESS;
          s_sel_d   = dec_sel;
          d_sel_d   = dec_dflt;
          s_addr_d  = dec_offset;
          s_write_d = m_write;
          s_wdata_d = m_wdata;
          d_addr_d  = m_addr;
`ifdef MMIO_TIMEOUT_EN
          tmo_cnt_d  = '0;
          pend_err_d = 1'b0;
`endif
        end
      end
      ST_ACCESS: begin
        if (ack_hit) begin
          state_d    = ST_RESP;
          rsp_data_d = sel_rdata;
          s_sel_d    = '0;
          d_sel_d    = 1'b0;
          s_write_d  = 1'b0;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          rsp_data_d = ERR_DATA;
          pend_err_d = 1'b1;
          s_sel_d    = '0;
          d_sel_d    = 1'b0;
          s_write_d  = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d   = ST_IDLE;
        m_ready_d = 1'b1;
        m_rdata_d = rsp_data_q;
`ifdef MMIO_TIMEOUT_EN
        m_err_d   = pend_err_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    m_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      m_busy_q   <= 1'b0;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= '0;
      rsp_data_q <= '0;
      s_sel_q    <= '0;
      s_write_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      d_sel_q    <= 1'b0;
      d_addr_q   <= '0;
`ifdef MMIO_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      pend_err_q <= 1'b0;
      m_err_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      m_busy_q   <= m_busy_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      rsp_data_q <= rsp_data_d;
      s_sel_q    <= s_sel_d;
      s_write_q  <= s_write_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      d_sel_q    <= d_sel_d;
      d_addr_q   <= d_addr_d;
`ifdef MMIO_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      pend_err_q <= pend_err_d;
      m_err_q    <= m_err_d;
`endif
    end
  end

`ifdef MMIO_TIMEOUT_EN
  assign m_err = m_err_q;
`else
  // Abort-path parameters have no function in this build.
  logic [DW-1:0] unused_cfg;
  assign unused_cfg = ERR_DATA ^ DW'(TIMEOUT);
  assign m_err      = 1'b0;
`endif

  assign m_busy  = m_busy_q;
  assign m_ready = m_ready_q;
  assign m_rdata = m_rdata_q;
  assign s_sel   = s_sel_q;
  assign s_write = s_write_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign d_sel   = d_sel_q;
  assign d_addr  = d_addr_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect: table of single accesses plus hand-written
// sequences for back-to-back, reset abort and watchdog behaviour.
module tb_mmio_interconnect;
  import mmio_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int NCH = 6;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              m_req = 1'b0;
  logic              m_write = 1'b0;
  logic [AW-1:0]     m_addr = '0;
  logic [DW-1:0]     m_wdata = '0;
  logic              m_busy, m_ready, m_err;
  logic [DW-1:0]     m_rdata;
  logic [NCH-1:0]    s_sel;
  logic              s_write;
  logic [3:0]        s_addr;
  logic [DW-1:0]     s_wdata;
  logic [NCH*DW-1:0] s_rdata;
  logic [NCH-1:0]    s_ack = '0;
  logic              d_sel;
  logic [AW-1:0]     d_addr;
  logic [DW-1:0]     d_rdata = 16'h5A5A;
  logic              d_ack = 1'b0;

  mmio_interconnect #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_sel(s_sel), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .d_sel(d_sel), .d_addr(d_addr), .d_rdata(d_rdata), .d_ack(d_ack)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic           wr;
    logic [15:0]    addr;
    logic [15:0]    wdata;
    int             dly;
    logic [NCH-1:0] noise;
    logic [NCH-1:0] sel;
    logic           dflt;
    logic [3:0]     saddr;
    logic [15:0]    rdata;
  } vec_t;

  vec_t        vt [8];
  logic [15:0] chdat [NCH];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    int   sel_cycles;
    logic early;
    m_req = 1'b1; m_write = v.wr; m_addr = v.addr; m_wdata = v.wdata;
    tick();
    m_req = 1'b0;
    chk($sformatf("v%0d s_sel", idx), 32'(s_sel), 32'(v.sel));
    chk($sformatf("v%0d d_sel", idx), 32'(d_sel), 32'(v.dflt));
    chk($sformatf("v%0d busy", idx), 32'(m_busy), 32'd1);
    chk($sformatf("v%0d s_write", idx), 32'(s_write), 32'(v.wr));
    if (v.dflt) chk($sformatf("v%0d d_addr", idx), 32'(d_addr), 32'(v.addr));
    else        chk($sformatf("v%0d s_addr", idx), 32'(s_addr), 32'(v.saddr));
    if (v.wr)   chk($sformatf("v%0d s_wdata", idx), 32'(s_wdata), 32'(v.wdata));
    s_ack = v.noise;
    sel_cycles = 1;
    early = 1'b0;
    for (int c = 0; c < v.dly; c++) begin
      tick();
      if (s_sel === v.sel && d_sel === v.dflt) sel_cycles++;
      if (m_ready !== 1'b0) early = 1'b1;
    end
    s_ack = v.noise | v.sel;
    d_ack = v.dflt;
    tick();
    s_ack = '0;
    d_ack = 1'b0;
    chk($sformatf("v%0d sel_cycles", idx), 32'(sel_cycles), 32'(v.dly + 1));
    chk($sformatf("v%0d early_ready", idx), 32'(early | m_ready), 32'd0);
    chk($sformatf("v%0d sel_drop", idx), 32'({s_sel, d_sel}), 32'd0);
    tick();
    chk($sformatf("v%0d m_ready", idx), 32'(m_ready), 32'd1);
    chk($sformatf("v%0d m_rdata", idx), 32'(m_rdata), 32'(v.rdata));
    chk($sformatf("v%0d m_err", idx), 32'(m_err), 32'd0);
    chk($sformatf("v%0d idle", idx), 32'(m_busy), 32'd0);
    tick();
    chk($sformatf("v%0d ready_pulse", idx), 32'(m_ready), 32'd0);
  endtask

  initial begin : main
    int   cnt;
    logic seen;

    chdat[CH_STATUS]    = 16'h1100;
    chdat[CH_ADDRSTACK] = 16'h2211;
    chdat[CH_USERSTACK] = 16'h3322;
    chdat[CH_UART]      = 16'h0041;
    chdat[CH_GPIO]      = 16'h5544;
    chdat[CH_GPIODIR]   = 16'h6655;
    for (int k = 0; k < NCH; k++) s_rdata[k*DW +: DW] = chdat[k];

    //         wr    addr      wdata     dly noise      sel        dflt  saddr rdata
    vt[0] = '{1'b0, 16'hFF31, 16'h0000, 0, 6'b000000, 6'b001000, 1'b0, 4'h1, 16'h0041};
    vt[1] = '{1'b1, 16'h0200, 16'h1234, 5, 6'b000000, 6'b000000, 1'b1, 4'h0, 16'h5A5A};
    vt[2] = '{1'b0, 16'hFF5F, 16'h0000, 1, 6'b000000, 6'b100000, 1'b0, 4'hF, 16'h6655};
    vt[3] = '{1'b0, 16'hFF60, 16'h0000, 0, 6'b000000, 6'b000000, 1'b1, 4'h0, 16'h5A5A};
    vt[4] = '{1'b0, 16'hFEFF, 16'h0000, 2, 6'b000000, 6'b000000, 1'b1, 4'h0, 16'h5A5A};
    vt[5] = '{1'b0, 16'hFF00, 16'h0000, 0, 6'b000000, 6'b000001, 1'b0, 4'h0, 16'h1100};
    vt[6] = '{1'b0, 16'hFF2A, 16'h0000, 3, 6'b000001, 6'b000100, 1'b0, 4'hA, 16'h3322};
    vt[7] = '{1'b1, 16'hFF47, 16'hBEEF, 0, 6'b000000, 6'b010000, 1'b0, 4'h7, 16'h5544};

    RST = 1'b1;
    tick(); tick();
    chk("reset ctrl", 32'({m_busy, m_ready, m_err, s_write, d_sel}), 32'd0);
    chk("reset s_sel", 32'(s_sel), 32'd0);
    chk("reset m_rdata", 32'(m_rdata), 32'd0);
    chk("reset s_bus", 32'({s_addr, s_wdata}), 32'd0);
    chk("reset d_addr", 32'(d_addr), 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) do_vec(i, vt[i]);

    // Held request: second access starts 3 cycles after the first.
    m_req = 1'b1; m_write = 1'b0; m_addr = 16'hFF10;
    tick();
    chk("b2b first sel", 32'(s_sel), 32'b000010);
    s_ack = 6'b000010;
    tick();
    s_ack = '0;
    chk("b2b resp", 32'({m_busy, m_ready}), 32'b10);
    m_addr = 16'hFF40;
    tick();
    chk("b2b ready1", 32'({m_ready, m_busy}), 32'b10);
    chk("b2b rdata1", 32'(m_rdata), 32'h2211);
    tick();
    m_req = 1'b0;
    chk("b2b second sel", 32'(s_sel), 32'b010000);
    chk("b2b ready drop", 32'(m_ready), 32'd0);
    s_ack = 6'b010000;
    tick();
    s_ack = '0;
    tick();
    chk("b2b ready2", 32'(m_ready), 32'd1);
    chk("b2b rdata2", 32'(m_rdata), 32'h5544);
    tick();

    // Reset during ACCESS abandons the access silently.
    m_req = 1'b1; m_addr = 16'h0300;
    tick();
    m_req = 1'b0;
    chk("rst pre d_sel", 32'(d_sel), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst sel/busy", 32'({s_sel, d_sel, m_busy}), 32'd0);
    seen = 1'b0;
    d_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (m_ready !== 1'b0) seen = 1'b1;
      tick();
      d_ack = 1'b0;
    end
    chk("rst no ready", 32'(seen), 32'd0);
    do_vec(8, vt[5]);

`ifdef MMIO_TIMEOUT_EN
    m_req = 1'b1; m_addr = 16'hFF20;
    tick();
    m_req = 1'b0;
    cnt = 0;
    while (s_sel[2] === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("tmo sel cycles", 32'(cnt), 32'd8);
    chk("tmo resp no ready", 32'(m_ready), 32'd0);
    tick();
    chk("tmo ready", 32'(m_ready), 32'd1);
    chk("tmo err", 32'(m_err), 32'd1);
    chk("tmo rdata", 32'(m_rdata), 32'hDEAD);
    tick();

    m_req = 1'b1; m_addr = 16'hFF20;
    tick();
    m_req = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    chk("tmo late sel", 32'(s_sel), 32'b000100);
    s_ack = 6'b000100;
    tick();
    s_ack = '0;
    tick();
    chk("tmo ack-wins ready", 32'(m_ready), 32'd1);
    chk("tmo ack-wins err", 32'(m_err), 32'd0);
    chk("tmo ack-wins rdata", 32'(m_rdata), 32'h3322);
    tick();
`else
    m_req = 1'b1; m_addr = 16'hFF20;
    tick();
    m_req = 1'b0;
    seen = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (s_sel === 6'b000100) cnt++;
      if (m_ready !== 1'b0 || m_err !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("wait sel held", 32'(cnt), 32'd40);
    chk("wait no ready", 32'(seen), 32'd0);
    s_ack = 6'b000100;
    tick();
    s_ack = '0;
    tick();
    chk("wait ready", 32'(m_ready), 32'd1);
    chk("wait err", 32'(m_err), 32'd0);
    chk("wait rdata", 32'(m_rdata), 32'h3322);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
